conv_fmap_collector: RTL

- Sink for the serial output stream of the 3x3 stride-1 merge convolution (`pxl_out`/`valid_out`).
- Captures one full output feature map of (D-2)x(D-2) words into on-chip storage.
- Once the map is complete, replays it in raster order over a valid/ready handshake to the next layer or a DMA writer.
- Decouples the convolution's free-running output from a back-pressured consumer.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/fmap_bank_ram.sv | 38 +++
 rtl/conv_fmap_collector.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution output-map collector.
package conv_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_LOAD = 2'd1,
    RD_SHOW = 2'd2
  } rd_state_e;

  // Side of the valid-region output of a 3x3 stride-1 convolution.
  function automatic int out_side(input int d);
    return d - 2;
  endfunction

  function automatic int ctr_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fmap_bank_ram.sv
// One feature-map bank: synchronous write port, registered read port.
module fmap_bank_ram #(
  parameter int DEPTH = 49,
  parameter int WIDTH = 32,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register holds its word until the next read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= '0;
    end else if (re) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/conv_fmap_collector.sv
// Captures one (D-2)x(D-2) convolution output map and replays it over valid/ready.
// Define CONV_FMAP_COLLECTOR_PINGPONG_EN for two banks (capture overlaps replay).
module conv_fmap_collector
  import conv_pkg::*;
#(
  parameter int D          = 9,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [data_width-1:0] pxl_in,
  input  logic                  ready_in,
  output logic [data_width-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic                  last_out,
  output logic                  overflow
);

  localparam int OD = out_side(D);
  localparam int N  = OD * OD;
  localparam int AW = ctr_width(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

`ifdef CONV_FMAP_COLLECTOR_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic [AW-1:0]         wr_idx_r;
  logic [AW-1:0]         rd_idx_r;
  logic                  wr_bank_r;
  logic                  rd_bank_r;
  logic [1:0]            full_r;
  rd_state_e             state_r;
  logic                  valid_out_r;
  logic                  last_out_r;
  logic                  frame_done_r;
  logic                  overflow_r;

  logic                  hs_s;
  logic                  final_hs_s;
  logic                  accept_s;
  logic                  drop_s;
  logic                  wr_last_s;
  logic                  load_now_s;
  logic                  re_s;
  logic [data_width-1:0] rd_data_s [NB];

  // Handshake, accept/drop and replay-start decisions for this cycle.
  always_comb begin
    hs_s       = valid_out_r && ready_in;
    final_hs_s = hs_s && (rd_idx_r == LAST_IDX);
    // A bank being released this cycle may take the incoming pixel.
    accept_s   = valid_in && (!full_r[wr_bank_r] ||
                              (final_hs_s && (rd_bank_r == wr_bank_r)));
    drop_s     = valid_in && !accept_s;
    wr_last_s  = accept_s && (wr_idx_r == LAST_IDX);
    load_now_s = full_r[rd_bank_r] || (wr_last_s && (wr_bank_r == rd_bank_r));
    re_s       = (state_r == RD_LOAD);
  end

  // Write pointer, bank select, frame_done pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_r     <= '0;
      wr_bank_r    <= 1'b0;
      frame_done_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      frame_done_r <= wr_last_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (accept_s) begin
        if (wr_last_s) begin
          wr_idx_r <= '0;
`ifdef CONV_FMAP_COLLECTOR_PINGPONG_EN
          wr_bank_r <= ~wr_bank_r;
`endif
        end else begin
          wr_idx_r <= wr_idx_r + AW'(1);
        end
      end
    end
  end

  // Bank-full flags: set on the last write, cleared on the last replay handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_last_s && (wr_bank_r == 1'(b))) begin
          full_r[b] <= 1'b1;
        end else if (final_hs_s && (rd_bank_r == 1'(b))) begin
          full_r[b] <= 1'b0;
        end
      end
    end
  end

  // Replay state machine; every word costs a LOAD cycle then a SHOW cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RD_IDLE;
      rd_idx_r    <= '0;
      rd_bank_r   <= 1'b0;
      valid_out_r <= 1'b0;
      last_out_r  <= 1'b0;
    end else begin
      case (state_r)
        RD_IDLE: begin
          if (load_now_s) begin
            state_r <= RD_LOAD;
          end
        end
        RD_LOAD: begin
          state_r     <= RD_SHOW;
          valid_out_r <= 1'b1;
          last_out_r  <= (rd_idx_r == LAST_IDX);
        end
        RD_SHOW: begin
          if (hs_s) begin
            valid_out_r <= 1'b0;
            last_out_r  <= 1'b0;
            if (final_hs_s) begin
              rd_idx_r <= '0;
              state_r  <= RD_IDLE;
`ifdef CONV_FMAP_COLLECTOR_PINGPONG_EN
              rd_bank_r <= ~rd_bank_r;
`endif
            end else begin
              rd_idx_r <= rd_idx_r + AW'(1);
              state_r  <= RD_LOAD;
            end
          end
        end
        default: begin
          state_r     <= RD_IDLE;
          valid_out_r <= 1'b0;
          last_out_r  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    fmap_bank_ram #(
      .DEPTH (N),
      .WIDTH (data_width),
      .AW    (AW)
    ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we      (accept_s && (wr_bank_r == 1'(b))),
      .wr_addr (wr_idx_r),
      .wr_data (pxl_in),
      .re      (re_s && (rd_bank_r == 1'(b))),
      .rd_addr (rd_idx_r),
      .rd_data (rd_data_s[b])
    );
  end

`ifdef CONV_FMAP_COLLECTOR_PINGPONG_EN
  assign pxl_out = rd_bank_r ? rd_data_s[1] : rd_data_s[0];
`else
  assign pxl_out = rd_data_s[0];
`endif

  assign valid_out  = valid_out_r;
  assign last_out   = last_out_r;
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;

endmodule
